// File: rtl/com_fifo_wr_arbiter.sv
// rtl/com_fifo_wr_arbiter.sv - round-robin Command FIFO write-port arbiter
// Owns registered winc/wdata, occupancy credit and the replay flush sequence.
module com_fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PKT_W = 64,
  parameter int DEPTH = 16
) (
  input  logic                   wclk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*PKT_W-1:0]  req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_wfull,
  output logic                   fifo_winc,
  output logic [PKT_W-1:0]       fifo_wdata,
  input  logic                   pop_done,
  input  logic                   replay_start,
  output logic                   replay_iter_flag,
  output logic                   flush_done,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              winc_q, winc_d;
  logic [PKT_W-1:0]  wdata_q, wdata_d;
  logic              iter_q, iter_d;
  logic              done_q, done_d;
  logic              can_acc, accept, pop_eff, found;
  logic [NREQ-1:0]   grant;
  logic [PW-1:0]     grant_idx;

  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (replay_start) state_d = DRAIN;
      DRAIN:   state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Round-robin search starting at rr_ptr_q, wrapping modulo NREQ.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_p     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(rr_ptr_q) + k) % NREQ;
      idx_p = PW'(idx);
      if (!found && req_valid[idx_p]) begin
        found        = 1'b1;
        grant[idx_p] = 1'b1;
        grant_idx    = idx_p;
      end
    end
  end

  always_comb begin
    can_acc   = (state_q == RUN) && (level_q < LW'(DEPTH)) && !fifo_wfull;
    req_ready = (reset && can_acc) ? grant : '0;
    accept    = |req_ready;
    // Flush wipes the count, so pops landing in FLUSH must not be applied.
    pop_eff   = pop_done && (level_q != '0) && (state_q != FLUSH);

    if (state_q == FLUSH)       level_d = '0;
    else if (accept && !pop_eff) level_d = level_q + LW'(1);
    else if (!accept && pop_eff) level_d = level_q - LW'(1);
    else                         level_d = level_q;

    winc_d  = accept;
    wdata_d = accept ? req_data[int'(grant_idx)*PKT_W +: PKT_W] : wdata_q;

    if (accept) rr_ptr_d = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
    else        rr_ptr_d = rr_ptr_q;

    iter_d = (state_d == FLUSH);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge wclk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      level_q  <= '0;
      winc_q   <= 1'b0;
      wdata_q  <= '0;
      iter_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      level_q  <= level_d;
      winc_q   <= winc_d;
      wdata_q  <= wdata_d;
      iter_q   <= iter_d;
      done_q   <= done_d;
    end
  end

  assign fifo_winc        = winc_q;
  assign fifo_wdata       = wdata_q;
  assign replay_iter_flag = iter_q;
  assign flush_done       = done_q;
  assign level            = level_q;
  assign busy             = (state_q != RUN);

endmodule

// File: tb/tb_com_fifo_wr_arbiter.sv
// tb/tb_com_fifo_wr_arbiter.sv - directed self-checking bench for com_fifo_wr_arbiter
module tb_com_fifo_wr_arbiter;
  logic         wclk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [255:0] req_data;
  logic [3:0]   req_ready;
  logic         fifo_wfull;
  logic         fifo_winc;
  logic [63:0]  fifo_wdata;
  logic         pop_done;
  logic         replay_start;
  logic         replay_iter_flag;
  logic         flush_done;
  logic [4:0]   level;
  logic         busy;
  int           total;
  int           bad;

  com_fifo_wr_arbiter #(.NREQ(4), .PKT_W(64), .DEPTH(16)) dut (
    .wclk(wclk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wfull(fifo_wfull), .fifo_winc(fifo_winc),
    .fifo_wdata(fifo_wdata), .pop_done(pop_done), .replay_start(replay_start),
    .replay_iter_flag(replay_iter_flag), .flush_done(flush_done), .level(level), .busy(busy)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge wclk);
    reset = 1'b0; req_valid = '0; pop_done = 1'b0; replay_start = 1'b0; fifo_wfull = 1'b0;
    repeat (2) @(negedge wclk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    total++; if (fifo_winc !== 1'b0) begin bad++; $display("FAIL rst_winc got=%b exp=0", fifo_winc); end
    total++; if (fifo_wdata !== 64'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", fifo_wdata); end
    total++; if (replay_iter_flag !== 1'b0) begin bad++; $display("FAIL rst_iter got=%b exp=0", replay_iter_flag); end
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL rst_flush_done got=%b exp=0", flush_done); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    @(negedge wclk); @(negedge wclk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready_clk got=%b exp=0000", req_ready); end
    total++; if (fifo_winc !== 1'b0) begin bad++; $display("FAIL rst_winc_clk got=%b exp=0", fifo_winc); end
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [63:0] pk [3];
    pk[0] = 64'hAAAA_0000_0000_0001; pk[1] = 64'hBBBB_0000_0000_0002; pk[2] = 64'hCCCC_0000_0000_0003;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        total++; if (fifo_winc !== 1'b1) begin bad++; $display("FAIL single_winc k=%0d got=%b exp=1", k, fifo_winc); end
        total++; if (fifo_wdata !== pk[k-1]) begin bad++; $display("FAIL single_wdata k=%0d got=%h exp=%h", k, fifo_wdata, pk[k-1]); end
        total++; if (level !== 5'(k)) begin bad++; $display("FAIL single_level k=%0d got=%0d exp=%0d", k, level, k); end
      end
      if (k < 3) begin
        req_valid = 4'b0001; req_data[63:0] = pk[k];
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready k=%0d got=%b exp=0001", k, req_ready); end
      end else begin
        req_valid = '0;
      end
      @(negedge wclk);
    end
    total++; if (fifo_winc !== 1'b0) begin bad++; $display("FAIL single_winc_end got=%b exp=0", fifo_winc); end
    total++; if (fifo_wdata !== pk[2]) begin bad++; $display("FAIL single_wdata_hold got=%h exp=%h", fifo_wdata, pk[2]); end
    total++; if (level !== 5'd3) begin bad++; $display("FAIL single_level_end got=%0d exp=3", level); end
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    do_reset();
    for (int r = 0; r < 4; r++) req_data[r*64 +: 64] = 64'h1000 + 64'(r);
    req_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      total++; if (level !== 5'(k)) begin bad++; $display("FAIL rr_level k=%0d got=%0d exp=%0d", k, level, k); end
      if (k > 0) begin
        total++; if (fifo_wdata !== 64'h1000 + 64'((k-1)%4)) begin bad++; $display("FAIL rr_wdata k=%0d got=%h", k, fifo_wdata); end
      end
      #1;
      e = 4'b0001 << (k % 4);
      total++; if (req_ready !== e) begin bad++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, e); end
      @(negedge wclk);
    end
    total++; if (level !== 5'd16) begin bad++; $display("FAIL rr_full_level got=%0d exp=16", level); end
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_full_ready got=%b exp=0000", req_ready); end
    pop_done = 1'b1;
    @(negedge wclk);
    pop_done = 1'b0;
    total++; if (level !== 5'd15) begin bad++; $display("FAIL rr_pop_level got=%0d exp=15", level); end
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rr_regrant got=%b exp=0001", req_ready); end
    @(negedge wclk);
    total++; if (level !== 5'd16) begin bad++; $display("FAIL rr_refill_level got=%0d exp=16", level); end
    total++; if (fifo_wdata !== 64'h1000) begin bad++; $display("FAIL rr_refill_wdata got=%h exp=1000", fifo_wdata); end
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_refull_ready got=%b exp=0000", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_valid = 4'b0001; req_data[63:0] = 64'h55;
    repeat (5) @(negedge wclk);
    total++; if (level !== 5'd5) begin bad++; $display("FAIL sim_pre_level got=%0d exp=5", level); end
    pop_done = 1'b1;
    @(negedge wclk);
    total++; if (level !== 5'd5) begin bad++; $display("FAIL sim_acc_pop_level got=%0d exp=5", level); end
    total++; if (fifo_winc !== 1'b1) begin bad++; $display("FAIL sim_acc_pop_winc got=%b exp=1", fifo_winc); end
    pop_done = 1'b0; fifo_wfull = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL sim_wfull_block got=%b exp=0000", req_ready); end
    @(negedge wclk);
    fifo_wfull = 1'b0; req_valid = '0;
    do_reset();
    pop_done = 1'b1;
    @(negedge wclk);
    pop_done = 1'b0;
    total++; if (level !== 5'd0) begin bad++; $display("FAIL sim_underflow got=%0d exp=0", level); end
  endtask

  task automatic test_replay();
    do_reset();
    req_valid = 4'b0001; req_data[63:0] = 64'h77;
    repeat (7) @(negedge wclk);
    total++; if (level !== 5'd7) begin bad++; $display("FAIL rp_pre_level got=%0d exp=7", level); end
    req_data[63:0] = 64'hD00D; replay_start = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rp_same_cycle_ready got=%b exp=0001", req_ready); end
    @(negedge wclk);
    replay_start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rp_drain_busy got=%b exp=1", busy); end
    total++; if (fifo_winc !== 1'b1 || fifo_wdata !== 64'hD00D) begin bad++; $display("FAIL rp_drain_write got=%b/%h exp=1/d00d", fifo_winc, fifo_wdata); end
    total++; if (level !== 5'd8) begin bad++; $display("FAIL rp_drain_level got=%0d exp=8", level); end
    total++; if (replay_iter_flag !== 1'b0) begin bad++; $display("FAIL rp_drain_iter got=%b exp=0", replay_iter_flag); end
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rp_drain_ready got=%b exp=0000", req_ready); end
    @(negedge wclk);
    total++; if (replay_iter_flag !== 1'b1) begin bad++; $display("FAIL rp_flush_iter got=%b exp=1", replay_iter_flag); end
    total++; if (busy !== 1'b1 || fifo_winc !== 1'b0) begin bad++; $display("FAIL rp_flush_busy_winc got=%b/%b exp=1/0", busy, fifo_winc); end
    pop_done = 1'b1;
    @(negedge wclk);
    pop_done = 1'b0;
    total++; if (flush_done !== 1'b1 || replay_iter_flag !== 1'b0) begin bad++; $display("FAIL rp_done_pulse got=%b/%b exp=1/0", flush_done, replay_iter_flag); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL rp_done_level got=%0d exp=0", level); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rp_done_busy got=%b exp=1", busy); end
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rp_done_ready got=%b exp=0000", req_ready); end
    @(negedge wclk);
    total++; if (busy !== 1'b0 || flush_done !== 1'b0) begin bad++; $display("FAIL rp_run_busy_done got=%b/%b exp=0/0", busy, flush_done); end
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rp_resume_ready got=%b exp=0001", req_ready); end
    @(negedge wclk);
    req_valid = '0;
    total++; if (fifo_winc !== 1'b1 || level !== 5'd1) begin bad++; $display("FAIL rp_resume_write got=%b/%0d exp=1/1", fifo_winc, level); end
  endtask

  task automatic test_replay_ignored();
    int pulses;
    pulses = 0;
    do_reset();
    replay_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge wclk);
      if (replay_iter_flag === 1'b1) pulses++;
      if (k == 3) replay_start = 1'b0;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ign_pulses got=%0d exp=1", pulses); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    req_valid = 4'b0001; req_data[63:0] = 64'h99;
    repeat (3) @(negedge wclk);
    req_valid = '0; replay_start = 1'b1;
    @(negedge wclk);
    replay_start = 1'b0;
    @(negedge wclk);
    total++; if (replay_iter_flag !== 1'b1 || level !== 5'd3) begin bad++; $display("FAIL mid_pre got=%b/%0d exp=1/3", replay_iter_flag, level); end
    reset = 1'b0;
    #1;
    total++; if (replay_iter_flag !== 1'b0) begin bad++; $display("FAIL mid_iter got=%b exp=0", replay_iter_flag); end
    total++; if (fifo_winc !== 1'b0 || level !== 5'd0) begin bad++; $display("FAIL mid_winc_level got=%b/%0d exp=0/0", fifo_winc, level); end
    total++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL mid_busy_ready got=%b/%b exp=0/0000", busy, req_ready); end
    @(negedge wclk);
    reset = 1'b1; req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
    @(posedge wclk);
    #1;
    total++; if (fifo_winc !== 1'b1) begin bad++; $display("FAIL mid_pending_pre got=%b exp=1", fifo_winc); end
    reset = 1'b0;
    #1;
    total++; if (fifo_winc !== 1'b0) begin bad++; $display("FAIL mid_pending_drop got=%b exp=0", fifo_winc); end
    @(negedge wclk);
    req_valid = '0; reset = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; req_valid = 4'b1111; req_data = '0; fifo_wfull = 1'b0;
    pop_done = 1'b0; replay_start = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_simultaneous();
    test_replay();
    test_replay_ignored();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/com_fifo_wr_arbiter.md
Name: com_fifo_wr_arbiter

Overview:
- Shares the single Command FIFO write port between NREQ command producers using round-robin arbitration.
- Owns the FIFO write side: registered winc/wdata, a local occupancy counter (credit tracking) and the replay flush sequence that drives replay_iter_flag.
- Sits between the command producers and the Command FIFO. The FIFO consumer reports each successful pop back through pop_done.

Parameters:
- NREQ, 4, number of requesters (>=2).
- PKT_W, 64, command packet width in bits (width of com_packet).
- DEPTH, 16, FIFO entries; must equal `com_fifo_size; power of two.

Ports:
- wclk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester command valid.
- req_data  in  NREQ*PKT_W  packets; requester i occupies bits [i*PKT_W +: PKT_W].
- req_ready  out  NREQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i].
- fifo_wfull  in  1  Command FIFO wfull.
- fifo_winc  out  1  Command FIFO write enable (registered).
- fifo_wdata  out  PKT_W  Command FIFO write data (registered).
- pop_done  in  1  consumer popped one entry (rinc & !empty) this cycle.
- replay_start  in  1  request FIFO flush for replay iteration (pulse).
- replay_iter_flag  out  1  drives the FIFO replay_iter_flag (registered, 1-cycle pulse).
- flush_done  out  1  1-cycle pulse one cycle after replay_iter_flag.
- level  out  $clog2(DEPTH)+1  committed occupancy.
- busy  out  1  state != RUN.

Behaviour:

Reset (reset=0, asynchronous):
- fifo_winc=0, fifo_wdata=0, replay_iter_flag=0, flush_done=0, level=0, rr_ptr=0, state=RUN.
- req_ready=0 while reset is asserted.

Accept condition:
- can_acc = (state==RUN) & (level<DEPTH) & !fifo_wfull.
- req_ready is combinational: one-hot grant to the first i with req_valid[i], searching from rr_ptr upward modulo NREQ, gated by can_acc.
- If no request is valid or can_acc=0, req_ready=0.

Write timing:
- On an accept at edge N: fifo_winc=1 and fifo_wdata=req_data[i] during cycle N+1.
- Otherwise fifo_winc=0 and fifo_wdata holds its last value.
- At most one accept per cycle; sustained throughput is 1 packet/cycle.

Round-robin pointer:
- On accept from requester i, rr_ptr <= (i+1) mod NREQ.
- With no accept, rr_ptr is unchanged.
- A requester holding req_valid is granted within NREQ accepting cycles.

Level counter:
- +1 on accept, -1 on pop_done; an accept and a pop_done in the same cycle leave it unchanged.
- pop_done at level==0 is ignored (no underflow).
- level counts at accept time, so the registered write can never overflow the FIFO.
- fifo_wfull=1 while level<DEPTH is a consistency error. Block accepts anyway; the bench flags it.

State machine:
- RUN: replay_start=1 -> DRAIN. An accept in the same cycle as replay_start is still taken and written.
- DRAIN: no accepts; wait 1 cycle so the in-flight fifo_winc retires -> FLUSH.
- FLUSH: replay_iter_flag=1 for exactly this cycle; level <= 0; pop_done ignored -> DONE.
- DONE: flush_done=1 for 1 cycle -> RUN. Accepts resume the following cycle.
- replay_start outside RUN is ignored. rr_ptr is preserved across a flush.

Reset mid-operation:
- Any state returns to RUN with all outputs cleared immediately.
- Any pending write is dropped.

Test Plan:
- Single requester: req_valid=4'b0001 with 3 packets A,B,C -> accepted on consecutive edges; fifo_winc high for 3 cycles, one cycle later; wdata A,B,C; level=3.
- All 4 valid continuously, no pops -> grant order 0,1,2,3,0,...; after 16 accepts level=16, req_ready=0; one pop_done -> exactly one more accept, level returns to 16.
- Simultaneous accept and pop_done at level=5 -> level stays 5; pop_done at level=0 -> level stays 0.
- replay_start at level=7, same cycle as an accept -> that write issues, level=8; 1 DRAIN cycle; replay_iter_flag one cycle; level=0; flush_done next cycle; busy high for 3 cycles; accepts resume.
- replay_start during DRAIN/FLUSH -> ignored; exactly one replay_iter_flag pulse.
- Assert reset low mid-FLUSH -> replay_iter_flag, fifo_winc, level drop to 0 asynchronously; after release the first request is granted from requester 0.
